// File: rtl/adc_pkg.sv
// Shared state encoding and parameter defaults for the serial ADC capture block.
package adc_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned CNV_CYCLES_DEF = 40;
  localparam int unsigned SCK_HALF_DEF   = 2;

  // Counter widths cover the parameter maxima (CNV_CYCLES <= 255, SCK_HALF <= 15).
  localparam int unsigned CNV_CNT_W = 8;
  localparam int unsigned SCK_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock generator: low-first square wave of SCK_HALF-cycle half periods while run_i,
// with combinational strobes flagging the edge at which adc_sck is about to rise or fall.
module adc_sck_gen
  import adc_pkg::*;
#(
  parameter int unsigned SCK_HALF = SCK_HALF_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clear_i,
  output logic sck_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [SCK_CNT_W-1:0] cnt_q, cnt_d;
  logic                 sck_q, sck_d;
  logic                 half_end_c;

  // Strobes depend only on registered state so the caller may feed clear_i from its next state.
  assign half_end_c = run_i && (cnt_q == SCK_CNT_W'(SCK_HALF - 1));
  assign rise_c_o   = half_end_c && !sck_q;
  assign fall_c_o   = half_end_c && sck_q;

  always_comb begin
    cnt_d = '0;
    sck_d = 1'b0;
    if (run_i && !clear_i) begin
      if (half_end_c) begin
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + SCK_CNT_W'(1);
        sck_d = sck_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/adc_serial_capture.sv
// Conversion/readout sequencer for a serial ADC: pulses adc_cnv, clocks DATA_W bits in MSB
// first, and holds a register-side sample word with valid and sticky overrun flags.
module adc_serial_capture
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned CNV_CYCLES = CNV_CYCLES_DEF,
  parameter int unsigned SCK_HALF   = SCK_HALF_DEF
) (
  input  logic              adc_clk,
  input  logic              adc_rst_n,
  input  logic              enable,
  input  logic              adc_rst,
  input  logic              reg_write,
  input  logic              reg_rst,
  input  logic              adc_sdo,
  output logic              adc_cnv,
  output logic              adc_sck,
  output logic              done,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              overrun
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

  state_e                state_q, state_d;
  logic [CNV_CNT_W-1:0]  cnv_cnt_q, cnv_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic [DATA_W-1:0]     sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  cnv_q, cnv_d;
  logic                  done_q, done_d;
  logic                  sck_run_c, sck_clear_c, sck_rise_c, sck_fall_c;

  assign sck_run_c   = (state_q == ST_SHIFT);
  assign sck_clear_c = (state_d != ST_SHIFT);

  adc_sck_gen #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_gen (
    .clk_i    (adc_clk),
    .rst_ni   (adc_rst_n),
    .run_i    (sck_run_c),
    .clear_i  (sck_clear_c),
    .sck_o    (adc_sck),
    .rise_c_o (sck_rise_c),
    .fall_c_o (sck_fall_c)
  );

  // Sequencing: every (re)entry into CONVERT starts from cleared counters and shift register.
  always_comb begin
    state_d   = state_q;
    cnv_cnt_d = cnv_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    if (!enable) begin
      state_d   = ST_IDLE;
      cnv_cnt_d = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CONVERT;
          cnv_cnt_d = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
        ST_CONVERT: begin
          if (adc_rst) begin
            cnv_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else if (cnv_cnt_q == CNV_CNT_W'(CNV_CYCLES - 1)) begin
            state_d   = ST_SHIFT;
            cnv_cnt_d = '0;
          end else begin
            cnv_cnt_d = cnv_cnt_q + CNV_CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (adc_rst) begin
            state_d   = ST_CONVERT;
            cnv_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else begin
            if (sck_rise_c) begin
              shreg_d   = DATA_W'({shreg_q, adc_sdo});
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
            // Leave only once the last bit's high phase has completed.
            if (sck_fall_c && (bit_cnt_q == BIT_CNT_W'(DATA_W))) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (adc_rst) begin
            state_d   = ST_CONVERT;
            cnv_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnv_cnt_d = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      endcase
    end
  end

  assign cnv_d  = (state_d == ST_CONVERT);
  assign done_d = (state_d == ST_DONE);

  // Register-side word: clear beats load; loading before a word is complete flags overrun.
  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (reg_rst) begin
      sample_d  = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else if (reg_write) begin
      sample_d = shreg_q;
      valid_d  = 1'b1;
      if (!done_q) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_q   <= ST_IDLE;
      cnv_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cnv_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnv_cnt_q <= cnv_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cnv_q     <= cnv_d;
      done_q    <= done_d;
    end
  end

  assign adc_cnv      = cnv_q;
  assign done         = done_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture with a behavioural ADC and a queue of expected words.
module tb_adc_serial_capture;

  localparam int unsigned DW = 16;

  logic          adc_clk   = 1'b0;
  logic          adc_rst_n = 1'b0;
  logic          enable    = 1'b0;
  logic          adc_rst   = 1'b0;
  logic          reg_write = 1'b0;
  logic          reg_rst   = 1'b0;
  logic          adc_sdo   = 1'b0;
  logic          adc_cnv, adc_sck, done, sample_valid, overrun;
  logic [DW-1:0] sample;

  logic [DW-1:0] adc_word = '0;
  logic [DW-1:0] adc_shift;
  int            bit_idx  = 0;
  int            n_asserts = 0;
  int            n_fail    = 0;
  logic [DW-1:0] exp_q[$];

  always #5 adc_clk = ~adc_clk;

  adc_serial_capture #(
    .DATA_W     (DW),
    .CNV_CYCLES (40),
    .SCK_HALF   (2)
  ) dut (
    .adc_clk      (adc_clk),
    .adc_rst_n    (adc_rst_n),
    .enable       (enable),
    .adc_rst      (adc_rst),
    .reg_write    (reg_write),
    .reg_rst      (reg_rst),
    .adc_sdo      (adc_sdo),
    .adc_cnv      (adc_cnv),
    .adc_sck      (adc_sck),
    .done         (done),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  // ADC model: MSB presented at conversion start, next bit after each sck rise.
  always @(posedge adc_cnv or posedge adc_sck) begin
    if (adc_cnv) bit_idx = 0;
    else         bit_idx = bit_idx + 1;
    adc_shift = adc_word << bit_idx;
    adc_sdo   = adc_shift[DW-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_expect(output logic [DW-1:0] w);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      w = '0;
    end else begin
      w = exp_q.pop_front();
    end
  endtask

  // Called at a negedge where adc_cnv is already high; t counts negedges from there.
  task automatic wait_done(output int cnv_len, output int rises, output int sck_hi,
                           output int done_at, output bit timeout);
    int   first;
    logic prev;
    cnv_len = 0; rises = 0; sck_hi = 0; done_at = -1; timeout = 1'b1;
    first = -1; prev = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (adc_cnv) begin
        if (first < 0) first = t;
        cnv_len++;
      end
      if (adc_sck && !prev) rises++;
      if (adc_sck) sck_hi++;
      if (done) begin
        done_at = t - first;
        timeout = 1'b0;
        break;
      end
      prev = adc_sck;
      @(negedge adc_clk);
    end
  endtask

  task automatic wait_rises(input int n, output bit timeout);
    int   r;
    logic prev;
    r = 0; prev = adc_sck; timeout = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge adc_clk);
      if (adc_sck && !prev) r++;
      prev = adc_sck;
      if (r == n) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_reg_write();
    reg_write = 1'b1;
    @(negedge adc_clk);
    reg_write = 1'b0;
  endtask

  initial begin
    int            cl, rs, hi, da;
    bit            to;
    logic [DW-1:0] w;

    // Reset state
    enable   = 1'b1;
    adc_word = 16'hA5C3;
    repeat (3) @(negedge adc_clk);
    check("rst_cnv", 32'(adc_cnv), 32'd0);
    check("rst_sck", 32'(adc_sck), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // First conversion straight out of reset
    exp_q.push_back(16'hA5C3);
    adc_rst_n = 1'b1;
    @(negedge adc_clk);
    check("first_cnv_after_release", 32'(adc_cnv), 32'd1);
    wait_done(cl, rs, hi, da, to);
    check("c1_timeout", 32'(to), 32'd0);
    check("c1_cnv_len", 32'(cl), 32'd40);
    check("c1_sck_rises", 32'(rs), 32'd16);
    check("c1_sck_high", 32'(hi), 32'd32);
    check("c1_done_at", 32'(da), 32'd104);
    check("c1_done_cnv", 32'(adc_cnv), 32'd0);
    check("c1_done_sck", 32'(adc_sck), 32'd0);
    pulse_reg_write();
    pop_expect(w);
    check("c1_sample", 32'(sample), 32'(w));
    check("c1_valid", 32'(sample_valid), 32'd1);
    check("c1_overrun", 32'(overrun), 32'd0);
    check("c1_done_held", 32'(done), 32'd1);

    // Restart, then abort after seven bits
    adc_rst  = 1'b1;
    adc_word = 16'h1234;
    @(negedge adc_clk);
    adc_rst = 1'b0;
    check("rs_cnv", 32'(adc_cnv), 32'd1);
    check("rs_done", 32'(done), 32'd0);
    wait_rises(7, to);
    check("ab_reach_bit7", 32'(to), 32'd0);
    adc_rst  = 1'b1;
    adc_word = 16'h3C5A;
    exp_q.push_back(16'h3C5A);
    @(negedge adc_clk);
    adc_rst = 1'b0;
    check("ab_sck_stopped", 32'(adc_sck), 32'd0);
    check("ab_cnv", 32'(adc_cnv), 32'd1);
    wait_done(cl, rs, hi, da, to);
    check("ab_timeout", 32'(to), 32'd0);
    check("ab_done_at", 32'(da), 32'd104);
    check("ab_sck_rises", 32'(rs), 32'd16);
    pulse_reg_write();
    pop_expect(w);
    check("ab_sample", 32'(sample), 32'(w));

    // reg_write during CONVERT -> overrun; then reg_rst beats reg_write
    adc_rst  = 1'b1;
    adc_word = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    @(negedge adc_clk);
    adc_rst = 1'b0;
    repeat (5) @(negedge adc_clk);
    pulse_reg_write();
    check("ov_overrun", 32'(overrun), 32'd1);
    check("ov_valid", 32'(sample_valid), 32'd1);
    check("ov_still_cnv", 32'(adc_cnv), 32'd1);
    reg_rst   = 1'b1;
    reg_write = 1'b1;
    @(negedge adc_clk);
    reg_rst   = 1'b0;
    reg_write = 1'b0;
    check("rr_sample", 32'(sample), 32'd0);
    check("rr_valid", 32'(sample_valid), 32'd0);
    check("rr_overrun", 32'(overrun), 32'd0);
    wait_done(cl, rs, hi, da, to);
    check("c3_timeout", 32'(to), 32'd0);
    check("c3_sck_rises", 32'(rs), 32'd16);

    // reg_write together with adc_rst while done
    reg_write = 1'b1;
    adc_rst   = 1'b1;
    adc_word  = 16'h5AA5;
    exp_q.push_back(16'h5AA5);
    @(negedge adc_clk);
    reg_write = 1'b0;
    adc_rst   = 1'b0;
    pop_expect(w);
    check("wr_rst_sample", 32'(sample), 32'(w));
    check("wr_rst_cnv", 32'(adc_cnv), 32'd1);
    check("wr_rst_done", 32'(done), 32'd0);
    check("wr_rst_overrun", 32'(overrun), 32'd0);
    wait_done(cl, rs, hi, da, to);
    check("c4_timeout", 32'(to), 32'd0);
    check("c4_cnv_len", 32'(cl), 32'd40);
    check("c4_done_at", 32'(da), 32'd104);
    pulse_reg_write();
    pop_expect(w);
    check("c4_sample", 32'(sample), 32'(w));

    // enable dropped mid-SHIFT
    adc_rst  = 1'b1;
    adc_word = 16'hFFFF;
    @(negedge adc_clk);
    adc_rst = 1'b0;
    wait_rises(4, to);
    check("en_reach_bit4", 32'(to), 32'd0);
    enable = 1'b0;
    @(negedge adc_clk);
    check("en_cnv", 32'(adc_cnv), 32'd0);
    check("en_sck", 32'(adc_sck), 32'd0);
    check("en_done", 32'(done), 32'd0);
    check("en_sample_kept", 32'(sample), 32'h5AA5);
    check("en_valid_kept", 32'(sample_valid), 32'd1);
    repeat (3) @(negedge adc_clk);
    check("idle_cnv", 32'(adc_cnv), 32'd0);
    check("idle_sck", 32'(adc_sck), 32'd0);
    enable = 1'b1;
    @(negedge adc_clk);
    check("reen_cnv", 32'(adc_cnv), 32'd1);

    // Asynchronous reset mid-CONVERT, observed between clock edges
    repeat (5) @(negedge adc_clk);
    #2;
    adc_rst_n = 1'b0;
    #1;
    check("arst_cnv", 32'(adc_cnv), 32'd0);
    check("arst_sck", 32'(adc_sck), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sample", 32'(sample), 32'd0);
    check("arst_valid", 32'(sample_valid), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    @(negedge adc_clk);
    check("arst_held_cnv", 32'(adc_cnv), 32'd0);
    adc_rst_n = 1'b1;
    @(negedge adc_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
